// File: rtl/pc_pkg.sv
// pc_pkg: op-code encodings and the op type shared by the PC sequencer and the decoder
package pc_pkg;
    typedef logic [2:0] pc_op_t;
    localparam pc_op_t PC_OP_NEXT   = 3'd0;
    localparam pc_op_t PC_OP_JUMP   = 3'd1;
    localparam pc_op_t PC_OP_BRANCH = 3'd2;
    localparam pc_op_t PC_OP_CALL   = 3'd3;
    localparam pc_op_t PC_OP_RET    = 3'd4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push on full overwrites the oldest entry
// Ports: clk, rst_n (async, active-low), push/pop strobes, din (pushed link),
//        top (most recent entry), count (valid entries), full, empty.
module pc_ras #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [AW-1:0]                  din,
    output logic [AW-1:0]                  top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH+1);
    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] wp, wp_inc, wp_dec;
    // wp is the next write slot; once full it points at the oldest entry
    assign wp_inc = (wp == PW'(RAS_DEPTH-1)) ? '0 : wp + 1'b1;
    assign wp_dec = (wp == '0) ? PW'(RAS_DEPTH-1) : wp - 1'b1;
    assign top    = mem[wp_dec];
    assign full   = count == CW'(RAS_DEPTH);
    assign empty  = count == '0;
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp    <= wp_inc;
            count <= full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            wp    <= wp_dec;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with jump, branch, call and return sequencing
// Ports: clk, rst_n (async, active-low), stall (hold everything), op (pc_pkg code),
//        br_taken, target (JUMP/CALL destination), offset (taken-branch displacement),
//        cur_pc, ras_count, ras_ovf / ras_unf (sticky overflow / underflow).
// Build option: define PC_RAS_EN to build the return-address stack; without it CALL acts
// as JUMP, RET as NEXT plus ras_unf, and ras_count / ras_ovf stay 0.
module pc_sequencer import pc_pkg::*; #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            INC       = 1,
    parameter int            RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [2:0]                     op,
    input  logic                           br_taken,
    input  logic [AW-1:0]                  target,
    input  logic [AW-1:0]                  offset,
    output logic [AW-1:0]                  cur_pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);
    localparam logic [AW-1:0] STEP = AW'(INC);
    logic [AW-1:0] inc_pc, next_pc, ras_top;
    logic          is_call, is_ret, ras_full, ras_empty;
    assign inc_pc  = cur_pc + STEP;
    assign is_call = pc_op_t'(op) == PC_OP_CALL;
    assign is_ret  = pc_op_t'(op) == PC_OP_RET;
`ifdef PC_RAS_EN
    pc_ras #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (!stall && is_call),
        .pop   (!stall && is_ret),
        .din   (inc_pc),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );
`else
    // a permanently empty stack: RET falls through and flags underflow
    assign ras_top   = inc_pc;
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_count = '0;
`endif
    always_comb begin
        next_pc = (pc_op_t'(op) == PC_OP_JUMP || is_call)     ? target :
                  (pc_op_t'(op) == PC_OP_BRANCH && br_taken)  ? cur_pc + offset :
                  (is_ret && !ras_empty)                      ? ras_top : inc_pc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pc  <= RESET_PC;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (!stall) begin
            cur_pc  <= next_pc;
            ras_ovf <= ras_ovf | (is_call && ras_full);
            ras_unf <= ras_unf | (is_ret && ras_empty);
        end
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the Redux-V core, replacing the plain 8-bit next-PC register. It holds the current PC and computes the next one internally from a fetch-stage opcode: sequential increment, absolute jump, conditional PC-relative branch, call and return. Call and return use an optional hardware return-address stack (RAS). It sits between the decode/branch-resolution logic and the instruction-memory address port.

## Interface
- `AW`, 8: PC / address width in bits.
- `RESET_PC`, 0: value loaded into `cur_pc` on reset (AW bits).
- `INC`, 1: sequential increment added for NEXT, not-taken BRANCH, CALL link and RET-underflow.
- `RAS_DEPTH`, 4: return-stack entries (≥2; used only with `PC_RAS_EN`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hold all state this cycle; `op` is ignored.
- `op`  in  3: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET; codes 5–7 reserved and treated as NEXT.
- `br_taken`  in  1: branch condition, sampled only when `op`=BRANCH.
- `target`  in  AW: absolute destination for JUMP/CALL.
- `offset`  in  AW: two's-complement displacement for a taken BRANCH.
- `cur_pc`  out  AW: registered current PC.
- `ras_count`  out  $clog2(RAS_DEPTH+1): valid stack entries.
- `ras_ovf`  out  1: sticky; a push occurred while the stack was full.
- `ras_unf`  out  1: sticky; a pop occurred while the stack was empty.

## Operation
- Reset (async assert, synchronous-to-`clk` release):
  - `cur_pc`=RESET_PC.
  - `ras_count`=0, `ras_ovf`=0, `ras_unf`=0.
  - Stack contents are don't-care.
- Each rising edge with `stall`=0, `cur_pc` updates by `op`:
  - NEXT: `cur_pc`+INC.
  - JUMP: `target`.
  - BRANCH: `cur_pc`+`offset` if `br_taken`, else `cur_pc`+INC.
  - CALL: push `cur_pc`+INC; `cur_pc`←`target`.
  - RET: pop the top entry into `cur_pc`.
- All arithmetic is modulo 2^AW. Wrap-around is silent, e.g. AW=8: 255+1→0; 10+0xF6(−10)→0.
- RAS is a LIFO with circular storage.
  - Push on full: overwrite the oldest entry, `ras_count` stays RAS_DEPTH, set `ras_ovf`.
  - Pop on empty: `cur_pc`←`cur_pc`+INC, `ras_count` stays 0, set `ras_unf`.
- Sticky flags clear only on reset.
- `stall`=1: `cur_pc`, stack, count and flags all hold, whatever `op` is.

## Timing
- `cur_pc` is a register output. A decision presented in cycle N is visible after edge N+1, i.e. 1-cycle latency, no combinational path from inputs to `cur_pc`.
- `ras_count` and the flags update on the same edge as the corresponding `cur_pc` change.
- CALL and RET each complete in one cycle. Back-to-back CALL/RET sequences are fully supported: RET immediately after CALL returns the just-pushed link.
- Reset asserted mid-sequence forces reset values immediately, without waiting for `clk`. Any in-flight op is discarded.

## Configuration
- `PC_RAS_EN` defined: RAS, `ras_count`, `ras_ovf`, `ras_unf` behave as above.
- `PC_RAS_EN` undefined: no stack storage is built.
  - CALL behaves as JUMP (no link saved).
  - RET behaves as NEXT and sets `ras_unf`.
  - `ras_count` and `ras_ovf` are tied to 0.
  - Ports remain present so the interface is unchanged.

## Structure
- Package `pc_pkg`: op-code localparams (`PC_OP_NEXT`…`PC_OP_RET`) and the `pc_op_t` 3-bit typedef, shared with the decoder.
- Sub-module `pc_ras`:
  - Parameters AW and RAS_DEPTH.
  - Push/pop/data-in/top-out, plus count, full and empty.
  - Circular pointer with overwrite-on-full.
  - Instantiated only under `PC_RAS_EN`.
- Top `pc_sequencer`: next-PC mux, adder, `cur_pc` register, sticky flags.

## Test plan
- Reset/sequential: RESET_PC=10, `rst_n` low then high, op=NEXT for 3 edges → `cur_pc` 10, 11, 12, 13; stall=1 for 2 edges → holds 13.
- Jump/branch: `cur_pc`=20; JUMP `target`=19 → 19; BRANCH `br_taken`=1 `offset`=0xFD → 16; BRANCH `br_taken`=0 → 17.
- Wrap: `cur_pc`=254 with NEXT, NEXT → 255, 0; BRANCH taken `offset`=3 from 0 → 3.
- Call/return (`PC_RAS_EN`): at 30 CALL `target`=100 → 100, `ras_count`=1; CALL `target`=200 → 200, count 2; RET → 101, count 1; RET → 31, count 0; flags stay 0.
- Overflow/underflow (DEPTH=4): 5 CALLs from PCs 0, 10, 20, 30, 40 → `ras_ovf`=1, count 4; 4 RETs → 41, 31, 21, 11; 5th RET → PC+1, `ras_unf`=1.
- Async reset mid-CALL: assert `rst_n` low between edges with count 2 → `cur_pc`=RESET_PC, count 0, flags 0 immediately. Repeat the CALL/RET scenario with `PC_RAS_EN` undefined → CALL acts as JUMP, RET → PC+1 and `ras_unf`=1.
